// File: rtl/mem_ctrl_byte.sv
// mem_ctrl_byte: byte-serial memory responder for the fetch and load/store stages.
// Takes a whole transaction (base address + length) from one of two requesters,
// walks the single-port byte RAM one byte per cycle, assembles read data
// little-endian or serialises store data, and pulses done to the owner.
module mem_ctrl_byte #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic [31:0]       if_data_o,
    output logic              if_done_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_len_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_done_o,
    output logic              mem_stall_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    localparam logic OWNER_IF  = 1'b0;
    localparam logic OWNER_MEM = 1'b1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] w_base_nxt;
    logic [2:0]        r_cnt;
    logic [2:0]        w_cnt_nxt;
    logic [2:0]        r_n;
    logic [2:0]        w_n_nxt;
    logic              r_owner;
    logic              w_owner_nxt;
    logic [31:0]       r_buf;
    logic [31:0]       w_buf_nxt;
    logic [23:0]       r_wdata_hi;
    logic [23:0]       w_wdata_hi_nxt;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [ADDR_W-1:0] w_ram_addr_nxt;
    logic              r_ram_we;
    logic              w_ram_we_nxt;
    logic [7:0]        r_ram_dout;
    logic [7:0]        w_ram_dout_nxt;
    logic [31:0]       r_if_data;
    logic [31:0]       w_if_data_nxt;
    logic              r_if_done;
    logic              w_if_done_nxt;
    logic [31:0]       r_mem_rdata;
    logic [31:0]       w_mem_rdata_nxt;
    logic              r_mem_done;
    logic              w_mem_done_nxt;

    logic [2:0]        w_len_n;
    logic              w_last;
    logic [ADDR_W-1:0] w_addr_inc;
    logic [31:0]       w_buf_merged;
    logic [7:0]        w_wbyte_next;
    logic              w_mem_ok;
    logic              w_if_ok;

    assign if_data_o   = r_if_data;
    assign if_done_o   = r_if_done;
    assign mem_rdata_o = r_mem_rdata;
    assign mem_done_o  = r_mem_done;
    assign mem_stall_o = mem_req_i & ~r_mem_done;
    assign ram_addr_o  = r_ram_addr;
    assign ram_we_o    = r_ram_we;
    assign ram_dout_o  = r_ram_dout;

    // A requester still seeing its own done pulse is mid-handshake, so it is not re-granted.
    assign w_mem_ok   = mem_req_i & ~r_mem_done;
    assign w_if_ok    = if_req_i & ~r_if_done & ~if_flush_i;
    assign w_last     = (r_cnt == (r_n - 3'd1));
    assign w_addr_inc = r_base + ADDR_W'(r_cnt + 3'd1);

    // Byte count from the load/store length code; the reserved code 10 means a full word.
    always_comb begin
        w_len_n = 3'd4;
        case (mem_len_i)
            2'b00:   w_len_n = 3'd1;
            2'b01:   w_len_n = 3'd2;
            default: w_len_n = 3'd4;
        endcase
    end

    // Drop the byte arriving from the RAM into its little-endian lane of the buffer.
    always_comb begin
        w_buf_merged = r_buf;
        case (r_cnt[1:0])
            2'd0:    w_buf_merged[7:0]   = ram_din_i;
            2'd1:    w_buf_merged[15:8]  = ram_din_i;
            2'd2:    w_buf_merged[23:16] = ram_din_i;
            default: w_buf_merged[31:24] = ram_din_i;
        endcase
    end

    // Pick the store byte that follows the one currently on the RAM bus.
    always_comb begin
        w_wbyte_next = 8'h00;
        case (r_cnt[1:0])
            2'd0:    w_wbyte_next = r_wdata_hi[7:0];
            2'd1:    w_wbyte_next = r_wdata_hi[15:8];
            2'd2:    w_wbyte_next = r_wdata_hi[23:16];
            default: w_wbyte_next = 8'h00;
        endcase
    end

    // Next-state and next-register logic: arbitration in IDLE, byte sequencing in RD/WR.
    always_comb begin
        w_state_nxt     = r_state;
        w_base_nxt      = r_base;
        w_cnt_nxt       = r_cnt;
        w_n_nxt         = r_n;
        w_owner_nxt     = r_owner;
        w_buf_nxt       = r_buf;
        w_wdata_hi_nxt  = r_wdata_hi;
        w_ram_addr_nxt  = r_ram_addr;
        w_ram_we_nxt    = r_ram_we;
        w_ram_dout_nxt  = r_ram_dout;
        w_if_data_nxt   = r_if_data;
        w_if_done_nxt   = 1'b0;
        w_mem_rdata_nxt = r_mem_rdata;
        w_mem_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_mem_ok) begin
                    w_base_nxt     = mem_addr_i;
                    w_n_nxt        = w_len_n;
                    w_owner_nxt    = OWNER_MEM;
                    w_cnt_nxt      = 3'd0;
                    w_ram_addr_nxt = mem_addr_i;
                    w_wdata_hi_nxt = mem_wdata_i[31:8];
                    if (mem_we_i) begin
                        w_ram_we_nxt   = 1'b1;
                        w_ram_dout_nxt = mem_wdata_i[7:0];
                        w_state_nxt    = S_WR;
                    end else begin
                        w_buf_nxt   = 32'h0;
                        w_state_nxt = S_RD;
                    end
                end else if (w_if_ok) begin
                    w_base_nxt     = if_addr_i;
                    w_n_nxt        = 3'd4;
                    w_owner_nxt    = OWNER_IF;
                    w_cnt_nxt      = 3'd0;
                    w_ram_addr_nxt = if_addr_i;
                    w_buf_nxt      = 32'h0;
                    w_state_nxt    = S_RD;
                end
            end
            S_RD: begin
                if ((r_owner == OWNER_IF) && if_flush_i) begin
                    w_buf_nxt   = 32'h0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_buf_nxt = w_buf_merged;
                    if (w_last) begin
                        w_state_nxt = S_IDLE;
                        if (r_owner == OWNER_MEM) begin
                            w_mem_rdata_nxt = w_buf_merged;
                            w_mem_done_nxt  = 1'b1;
                        end else begin
                            w_if_data_nxt = w_buf_merged;
                            w_if_done_nxt = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt      = r_cnt + 3'd1;
                        w_ram_addr_nxt = w_addr_inc;
                    end
                end
            end
            S_WR: begin
                if (w_last) begin
                    w_ram_we_nxt   = 1'b0;
                    w_mem_done_nxt = 1'b1;
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_cnt_nxt      = r_cnt + 3'd1;
                    w_ram_addr_nxt = w_addr_inc;
                    w_ram_dout_nxt = w_wbyte_next;
                end
            end
            default: begin
                w_ram_we_nxt = 1'b0;
                w_state_nxt  = S_IDLE;
            end
        endcase
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Transaction bookkeeping and registered outputs, all cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base      <= '0;
            r_cnt       <= 3'd0;
            r_n         <= 3'd0;
            r_owner     <= OWNER_IF;
            r_buf       <= 32'h0;
            r_wdata_hi  <= 24'h0;
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_dout  <= 8'h00;
            r_if_data   <= 32'h0;
            r_if_done   <= 1'b0;
            r_mem_rdata <= 32'h0;
            r_mem_done  <= 1'b0;
        end else begin
            r_base      <= w_base_nxt;
            r_cnt       <= w_cnt_nxt;
            r_n         <= w_n_nxt;
            r_owner     <= w_owner_nxt;
            r_buf       <= w_buf_nxt;
            r_wdata_hi  <= w_wdata_hi_nxt;
            r_ram_addr  <= w_ram_addr_nxt;
            r_ram_we    <= w_ram_we_nxt;
            r_ram_dout  <= w_ram_dout_nxt;
            r_if_data   <= w_if_data_nxt;
            r_if_done   <= w_if_done_nxt;
            r_mem_rdata <= w_mem_rdata_nxt;
            r_mem_done  <= w_mem_done_nxt;
        end
    end

endmodule

// File: tb/tb_mem_ctrl_byte.sv
// tb_mem_ctrl_byte: bench for the byte-serial memory controller, with a byte RAM
// model and scoreboards of expected done pulses and expected RAM writes.
module tb_mem_ctrl_byte;

    localparam int ADDR_W = 32;

    logic              clk;
    logic              rst;
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_flush_i;
    logic [31:0]       if_data_o;
    logic              if_done_o;
    logic              mem_req_i;
    logic              mem_we_i;
    logic [1:0]        mem_len_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [31:0]       mem_wdata_i;
    logic [31:0]       mem_rdata_o;
    logic              mem_done_o;
    logic              mem_stall_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic              ram_we_o;
    logic [7:0]        ram_dout_o;
    logic [7:0]        ram_din_i;

    typedef struct {
        logic        isMem;
        logic        checkData;
        logic [31:0] data;
    } doneExp_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } wrExp_t;

    doneExp_t doneQ[$];
    wrExp_t   wrQ[$];
    int       testsRun    = 0;
    int       testsFailed = 0;

    logic [7:0]  ramMem [0:65535];
    logic        preloadEn;
    logic [15:0] preloadAddr;
    logic [7:0]  preloadData;

    doneExp_t    monDone;
    wrExp_t      monWr;
    logic [31:0] monData;

    mem_ctrl_byte #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_flush_i  (if_flush_i),
        .if_data_o   (if_data_o),
        .if_done_o   (if_done_o),
        .mem_req_i   (mem_req_i),
        .mem_we_i    (mem_we_i),
        .mem_len_i   (mem_len_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_rdata_o (mem_rdata_o),
        .mem_done_o  (mem_done_o),
        .mem_stall_o (mem_stall_o),
        .ram_addr_o  (ram_addr_o),
        .ram_we_o    (ram_we_o),
        .ram_dout_o  (ram_dout_o),
        .ram_din_i   (ram_din_i)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: read data for the address presented last edge is there by the next edge.
    assign ram_din_i = ramMem[ram_addr_o[15:0]];

    // RAM model write port, plus a preload path used while the DUT is held in reset.
    always @(posedge clk) begin
        if (preloadEn) begin
            ramMem[preloadAddr] <= preloadData;
        end else if (!rst && ram_we_o) begin
            ramMem[ram_addr_o[15:0]] <= ram_dout_o;
        end
    end

    // Scoreboard: every done pulse and every RAM write must match the front of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (if_done_o || mem_done_o) begin
                testsRun++;
                if (doneQ.size() == 0) begin
                    testsFailed++;
                    $display("[TB] FAIL done_unexpected: if_done=%0b mem_done=%0b, expected no done", if_done_o, mem_done_o);
                end else begin
                    monDone = doneQ.pop_front();
                    monData = monDone.isMem ? mem_rdata_o : if_data_o;
                    if ({mem_done_o, if_done_o} !== {monDone.isMem, ~monDone.isMem} ||
                        (monDone.checkData && monData !== monDone.data)) begin
                        testsFailed++;
                        $display("[TB] FAIL done_data: got mem_done=%0b if_done=%0b data=%h, expected mem=%0b data=%h",
                                 mem_done_o, if_done_o, monData, monDone.isMem, monDone.data);
                    end
                end
            end
            if (ram_we_o) begin
                testsRun++;
                if (wrQ.size() == 0) begin
                    testsFailed++;
                    $display("[TB] FAIL write_unexpected: addr=%h byte=%h, expected no write", ram_addr_o, ram_dout_o);
                end else begin
                    monWr = wrQ.pop_front();
                    if (ram_addr_o !== monWr.addr || ram_dout_o !== monWr.data) begin
                        testsFailed++;
                        $display("[TB] FAIL write_byte: got addr=%h byte=%h, expected addr=%h byte=%h",
                                 ram_addr_o, ram_dout_o, monWr.addr, monWr.data);
                    end
                end
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void expectDone(input logic isMem, input logic chk, input logic [31:0] data);
        doneExp_t e;
        e.isMem     = isMem;
        e.checkData = chk;
        e.data      = data;
        doneQ.push_back(e);
    endfunction

    function automatic void expectWrite(input logic [31:0] addr, input logic [7:0] data);
        wrExp_t e;
        e.addr = addr;
        e.data = data;
        wrQ.push_back(e);
    endfunction

    task automatic test_reset();
        logic [15:0] preAddr [14];
        logic [7:0]  preData [14];
        preAddr = '{16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h2000, 16'h2001, 16'h0400,
                    16'h0401, 16'h0402, 16'h0403, 16'h0200, 16'h0201, 16'h0202, 16'h0203};
        preData = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h34, 8'h12, 8'h11,
                    8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        @(negedge clk);
        testsRun++;
        if ({ram_addr_o, ram_we_o, ram_dout_o, if_data_o, if_done_o, mem_rdata_o, mem_done_o} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got addr=%h we=%0b dout=%h ifd=%h ifdone=%0b memd=%h memdone=%0b, expected all 0",
                     ram_addr_o, ram_we_o, ram_dout_o, if_data_o, if_done_o, mem_rdata_o, mem_done_o);
        end
        testsRun++;
        if (mem_stall_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_stall: got %0b, expected 0", mem_stall_o);
        end
        for (int i = 0; i < 14; i++) begin
            preloadEn   = 1'b1;
            preloadAddr = preAddr[i];
            preloadData = preData[i];
            @(negedge clk);
        end
        preloadEn = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        testsRun++;
        if ({ram_addr_o, ram_we_o, if_done_o, mem_done_o} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_release_idle: got addr=%h we=%0b ifdone=%0b memdone=%0b, expected all 0",
                     ram_addr_o, ram_we_o, if_done_o, mem_done_o);
        end
    endtask

    task automatic test_fetch();
        logic [31:0] expA;
        if_req_i  = 1'b1;
        if_addr_i = 32'h0000_0100;
        expectDone(1'b0, 1'b1, 32'h0000_0513);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 2) if_addr_i = 32'hDEAD_0000;
            expA = 32'h0000_0100 + 32'(k - 1);
            testsRun++;
            if (ram_addr_o !== expA || ram_we_o !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL fetch_addr: got addr=%h we=%0b, expected addr=%h we=0", ram_addr_o, ram_we_o, expA);
            end
            testsRun++;
            if (if_done_o !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL fetch_early_done: got %0b in cycle %0d, expected 0", if_done_o, k);
            end
        end
        @(negedge clk);
        testsRun++;
        if (if_done_o !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL fetch_done_latency: got %0b, expected 1", if_done_o);
        end
        @(negedge clk);
        testsRun++;
        if (ram_addr_o !== 32'h0000_0103 || if_done_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL fetch_no_regrant: got addr=%h done=%0b, expected addr=00000103 done=0", ram_addr_o, if_done_o);
        end
        if_req_i = 1'b0;
        repeat (3) @(negedge clk);
        testsRun++;
        if (ram_addr_o !== 32'h0000_0103 || if_data_o !== 32'h0000_0513) begin
            testsFailed++;
            $display("[TB] FAIL fetch_hold: got addr=%h data=%h, expected 00000103 00000513", ram_addr_o, if_data_o);
        end
    endtask

    task automatic test_load_priority();
        logic [31:0] expA;
        mem_req_i  = 1'b1;
        mem_we_i   = 1'b0;
        mem_len_i  = 2'b01;
        mem_addr_i = 32'h0000_2000;
        if_req_i   = 1'b1;
        if_addr_i  = 32'h0000_0400;
        expectDone(1'b1, 1'b1, 32'h0000_1234);
        expectDone(1'b0, 1'b1, 32'h4433_2211);
        #1;
        testsRun++;
        if (mem_stall_o !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL load_stall: got %0b, expected 1", mem_stall_o);
        end
        @(negedge clk);
        testsRun++;
        if (ram_addr_o !== 32'h0000_2000) begin
            testsFailed++;
            $display("[TB] FAIL load_priority: got addr=%h, expected 00002000", ram_addr_o);
        end
        @(negedge clk);
        @(negedge clk);
        testsRun++;
        if (mem_done_o !== 1'b1 || mem_stall_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL load_done: got done=%0b stall=%0b, expected done=1 stall=0", mem_done_o, mem_stall_o);
        end
        @(negedge clk);
        testsRun++;
        if (ram_addr_o !== 32'h0000_0400 || mem_done_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL fetch_after_load: got addr=%h mem_done=%0b, expected 00000400 0", ram_addr_o, mem_done_o);
        end
        mem_req_i = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            expA = 32'h0000_0400 + 32'(k);
            testsRun++;
            if (ram_addr_o !== expA) begin
                testsFailed++;
                $display("[TB] FAIL fetch2_addr: got %h, expected %h", ram_addr_o, expA);
            end
        end
        @(negedge clk);
        testsRun++;
        if (if_done_o !== 1'b1 || mem_rdata_o !== 32'h0000_1234) begin
            testsFailed++;
            $display("[TB] FAIL fetch2_done: got done=%0b rdata=%h, expected done=1 rdata=00001234", if_done_o, mem_rdata_o);
        end
        @(negedge clk);
        if_req_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store();
        mem_req_i   = 1'b1;
        mem_we_i    = 1'b1;
        mem_len_i   = 2'b11;
        mem_addr_i  = 32'h0000_0030;
        mem_wdata_i = 32'hDEAD_BEEF;
        expectWrite(32'h0000_0030, 8'hEF);
        expectWrite(32'h0000_0031, 8'hBE);
        expectWrite(32'h0000_0032, 8'hAD);
        expectWrite(32'h0000_0033, 8'hDE);
        expectDone(1'b1, 1'b0, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                mem_wdata_i = 32'h0;
                mem_addr_i  = 32'h0000_9999;
            end
            testsRun++;
            if (ram_we_o !== 1'b1 || mem_done_o !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL store_we: got we=%0b done=%0b in cycle %0d, expected we=1 done=0", ram_we_o, mem_done_o, k);
            end
        end
        @(negedge clk);
        testsRun++;
        if (mem_done_o !== 1'b1 || ram_we_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL store_done: got done=%0b we=%0b, expected done=1 we=0", mem_done_o, ram_we_o);
        end
        @(negedge clk);
        mem_req_i = 1'b0;
        mem_we_i  = 1'b0;
        testsRun++;
        if (ramMem[16'h0030] !== 8'hEF || ramMem[16'h0033] !== 8'hDE) begin
            testsFailed++;
            $display("[TB] FAIL store_ram: got %h..%h, expected ef..de", ramMem[16'h0030], ramMem[16'h0033]);
        end
        @(negedge clk);
    endtask

    task automatic test_flush();
        logic [31:0] expA;
        if_req_i   = 1'b1;
        if_addr_i  = 32'h0000_0600;
        if_flush_i = 1'b1;
        repeat (2) begin
            @(negedge clk);
            testsRun++;
            if (ram_addr_o !== 32'h0000_0033 || ram_we_o !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL flush_idle_grant: got addr=%h we=%0b, expected 00000033 0", ram_addr_o, ram_we_o);
            end
        end
        if_req_i    = 1'b0;
        mem_req_i   = 1'b1;
        mem_we_i    = 1'b0;
        mem_len_i   = 2'b00;
        mem_addr_i  = 32'h0000_2001;
        expectDone(1'b1, 1'b1, 32'h0000_0012);
        @(negedge clk);
        testsRun++;
        if (ram_addr_o !== 32'h0000_2001) begin
            testsFailed++;
            $display("[TB] FAIL flush_mem_addr: got %h, expected 00002001", ram_addr_o);
        end
        @(negedge clk);
        testsRun++;
        if (mem_done_o !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL flush_mem_done: got %0b, expected 1", mem_done_o);
        end
        @(negedge clk);
        mem_req_i  = 1'b0;
        if_flush_i = 1'b0;
        if_req_i   = 1'b1;
        if_addr_i  = 32'h0000_0500;
        @(negedge clk);
        @(negedge clk);
        testsRun++;
        if (ram_addr_o !== 32'h0000_0501) begin
            testsFailed++;
            $display("[TB] FAIL flush_fetch_start: got %h, expected 00000501", ram_addr_o);
        end
        if_flush_i = 1'b1;
        @(negedge clk);
        if_flush_i = 1'b0;
        if_addr_i  = 32'h0000_0200;
        testsRun++;
        if (ram_addr_o !== 32'h0000_0501 || if_done_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL flush_abort: got addr=%h done=%0b, expected 00000501 0", ram_addr_o, if_done_o);
        end
        expectDone(1'b0, 1'b1, 32'hDDCC_BBAA);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            expA = 32'h0000_0200 + 32'(k);
            testsRun++;
            if (ram_addr_o !== expA || if_done_o !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL flush_refetch: got addr=%h done=%0b, expected %h 0", ram_addr_o, if_done_o, expA);
            end
        end
        @(negedge clk);
        testsRun++;
        if (if_done_o !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL flush_refetch_done: got %0b, expected 1", if_done_o);
        end
        @(negedge clk);
        if_req_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        mem_req_i   = 1'b1;
        mem_we_i    = 1'b1;
        mem_len_i   = 2'b10;
        mem_addr_i  = 32'hFFFF_FFFE;
        mem_wdata_i = 32'h4433_2211;
        expectWrite(32'hFFFF_FFFE, 8'h11);
        expectWrite(32'hFFFF_FFFF, 8'h22);
        expectWrite(32'h0000_0000, 8'h33);
        expectWrite(32'h0000_0001, 8'h44);
        expectDone(1'b1, 1'b0, 32'h0);
        repeat (5) @(negedge clk);
        testsRun++;
        if (mem_done_o !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL wrap_store_done: got %0b, expected 1", mem_done_o);
        end
        @(negedge clk);
        mem_we_i  = 1'b0;
        mem_len_i = 2'b11;
        expectDone(1'b1, 1'b1, 32'h4433_2211);
        repeat (3) @(negedge clk);
        testsRun++;
        if (ram_addr_o !== 32'h0000_0000) begin
            testsFailed++;
            $display("[TB] FAIL wrap_load_addr: got %h, expected 00000000", ram_addr_o);
        end
        repeat (2) @(negedge clk);
        testsRun++;
        if (mem_done_o !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL wrap_load_done: got %0b, expected 1", mem_done_o);
        end
        @(negedge clk);
        mem_req_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_store();
        mem_req_i   = 1'b1;
        mem_we_i    = 1'b1;
        mem_len_i   = 2'b11;
        mem_addr_i  = 32'h0000_0700;
        mem_wdata_i = 32'h5566_7788;
        expectWrite(32'h0000_0700, 8'h88);
        expectWrite(32'h0000_0701, 8'h77);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        testsRun++;
        if (ram_we_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL rst_we_async: got %0b, expected 0", ram_we_o);
        end
        testsRun++;
        if ({ram_addr_o, ram_dout_o, if_data_o, if_done_o, mem_rdata_o, mem_done_o} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL rst_outputs: got addr=%h dout=%h ifd=%h memd=%h, expected all 0",
                     ram_addr_o, ram_dout_o, if_data_o, mem_rdata_o);
        end
        @(negedge clk);
        rst = 1'b0;
        expectWrite(32'h0000_0700, 8'h88);
        expectWrite(32'h0000_0701, 8'h77);
        expectWrite(32'h0000_0702, 8'h66);
        expectWrite(32'h0000_0703, 8'h55);
        expectDone(1'b1, 1'b0, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            testsRun++;
            if (mem_done_o !== 1'b0 || ram_we_o !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL rst_regrant: got done=%0b we=%0b in cycle %0d, expected done=0 we=1", mem_done_o, ram_we_o, k);
            end
        end
        @(negedge clk);
        testsRun++;
        if (mem_done_o !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL rst_regrant_done: got %0b, expected 1", mem_done_o);
        end
        @(negedge clk);
        mem_req_i = 1'b0;
        mem_we_i  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        if_req_i    = 1'b0;
        if_addr_i   = '0;
        if_flush_i  = 1'b0;
        mem_req_i   = 1'b0;
        mem_we_i    = 1'b0;
        mem_len_i   = 2'b00;
        mem_addr_i  = '0;
        mem_wdata_i = 32'h0;
        preloadEn   = 1'b0;
        preloadAddr = 16'h0;
        preloadData = 8'h00;

        test_reset();
        test_fetch();
        test_load_priority();
        test_store();
        test_flush();
        test_wrap();
        test_reset_mid_store();

        testsRun++;
        if (doneQ.size() != 0 || wrQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard_drain: got %0d dones and %0d writes outstanding, expected 0 and 0", doneQ.size(), wrQ.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
